// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader that fills the CPU instruction and data memories from
//   a byte stream, keeps the pipelined CPU in reset while loading, and
//   releases it on a RUN command.
//
//   Stream commands (only recognised in IDLE):
//     0xA1 count addr payload  -> IMEM load, 4*(count+1) bytes, LE words
//     0xA2 count addr payload  -> DMEM load, count+1 bytes
//     0xA3                     -> RUN (CPU out of reset until 0xA4)
//     anything else            -> dropped, sets the sticky err flag
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid, in_data     stream byte and its valid
//   in_ready              registered, 1 from the first edge after reset
//   imem_we/addr/wdata    instruction-memory word write port
//   dmem_we/addr/wdata    data-memory byte write port
//   cpu_rst_n             CPU reset, low everywhere except in RUN
//   err                   sticky unknown-command flag
module imem_loader #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [7:0]         dmem_wdata,
  output logic               cpu_rst_n,
  output logic               err
);

  localparam logic [7:0] CMD_IMEM = 8'hA1;
  localparam logic [7:0] CMD_DMEM = 8'hA2;
  localparam logic [7:0] CMD_RUN  = 8'hA3;
  localparam logic [7:0] CMD_HALT = 8'hA4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT,
    S_ADDR,
    S_DATA,
    S_RUN
  } state_t;

  state_t             state_q, state_d;
  logic               is_imem_q, is_imem_d;
  logic [8:0]         remain_q, remain_d;
  logic [1:0]         lane_q, lane_d;
  logic [23:0]        part_q, part_d;
  logic [IMEM_AW-1:0] iaddr_next_q, iaddr_next_d;
  logic [DMEM_AW-1:0] daddr_next_q, daddr_next_d;

  logic               imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_d;
  logic [31:0]        imem_wdata_d;
  logic               dmem_we_d;
  logic [DMEM_AW-1:0] dmem_addr_d;
  logic [7:0]         dmem_wdata_d;
  logic               err_d;

  logic xfer;
  assign xfer = in_valid & in_ready;

  // Every output is a register so strobes, addresses and data line up in
  // the cycle after the accepting edge; a reset drops everything at once,
  // discarding any partially assembled word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_imem_q    <= 1'b0;
      remain_q     <= '0;
      lane_q       <= '0;
      part_q       <= '0;
      iaddr_next_q <= '0;
      daddr_next_q <= '0;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      cpu_rst_n    <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_imem_q    <= is_imem_d;
      remain_q     <= remain_d;
      lane_q       <= lane_d;
      part_q       <= part_d;
      iaddr_next_q <= iaddr_next_d;
      daddr_next_q <= daddr_next_d;
      in_ready     <= 1'b1;
      imem_we      <= imem_we_d;
      imem_addr    <= imem_addr_d;
      imem_wdata   <= imem_wdata_d;
      dmem_we      <= dmem_we_d;
      dmem_addr    <= dmem_addr_d;
      dmem_wdata   <= dmem_wdata_d;
      cpu_rst_n    <= (state_d == S_RUN);
      err          <= err_d;
    end
  end

  // Next-state and datapath. Everything holds unless a byte is transferred;
  // strobes default low so each write is a single-cycle pulse.
  always_comb begin
    state_d      = state_q;
    is_imem_d    = is_imem_q;
    remain_d     = remain_q;
    lane_d       = lane_q;
    part_d       = part_q;
    iaddr_next_d = iaddr_next_q;
    daddr_next_d = daddr_next_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr;
    dmem_wdata_d = dmem_wdata;
    err_d        = err;

    if (xfer) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_data == CMD_IMEM) begin
            is_imem_d = 1'b1;
            state_d   = S_CNT;
          end else if (in_data == CMD_DMEM) begin
            is_imem_d = 1'b0;
            state_d   = S_CNT;
          end else if (in_data == CMD_RUN) begin
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end

        // Count byte C means C+1 items (words or bytes), so 1..256 fits 9 bits.
        S_CNT: begin
          remain_d = {1'b0, in_data} + 9'd1;
          state_d  = S_ADDR;
        end

        // Start address; upper byte bits beyond the memory width are dropped.
        S_ADDR: begin
          if (is_imem_q) begin
            iaddr_next_d = IMEM_AW'(in_data);
          end else begin
            daddr_next_d = DMEM_AW'(in_data);
          end
          lane_d  = 2'd0;
          state_d = S_DATA;
        end

        S_DATA: begin
          if (is_imem_q) begin
            lane_d = lane_q + 2'd1;
            unique case (lane_q)
              2'd0: part_d[7:0]   = in_data;
              2'd1: part_d[15:8]  = in_data;
              2'd2: part_d[23:16] = in_data;
              default: begin
                imem_we_d    = 1'b1;
                imem_addr_d  = iaddr_next_q;
                imem_wdata_d = {in_data, part_q};
                iaddr_next_d = iaddr_next_q + IMEM_AW'(1);
                remain_d     = remain_q - 9'd1;
                if (remain_q == 9'd1) state_d = S_IDLE;
              end
            endcase
          end else begin
            dmem_we_d    = 1'b1;
            dmem_addr_d  = daddr_next_q;
            dmem_wdata_d = in_data;
            daddr_next_d = daddr_next_q + DMEM_AW'(1);
            remain_d     = remain_q - 9'd1;
            if (remain_q == 9'd1) state_d = S_IDLE;
          end
        end

        // CPU runs; every byte is swallowed except HALT.
        S_RUN: begin
          if (in_data == CMD_HALT) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
